// File: rtl/shift_div_pkg.sv
// Shared types and constants for the shift/subtract divider.
package shift_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_VW = 4;

  // Wide enough for any practical DW; truncated to DW at the use site.
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Request/result bundle between a requester and the divider.
interface shift_sub_divider_if
  import shift_div_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned VW = DEF_VW
);

  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/shift_sub_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract if it fits.
module shift_sub_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW-1:0] i_r_in,
  input  logic          i_bit,
  input  logic [VW-1:0] i_divisor,
  output logic [VW-1:0] o_r_out_c,
  output logic          o_qbit_c
);

  logic [VW:0] w_shift;
  logic [VW:0] w_dvs;

  assign w_shift  = {i_r_in, i_bit};
  assign w_dvs    = {1'b0, i_divisor};
  assign o_qbit_c = (w_shift >= w_dvs);

  // The restored value is always below the divisor, so it fits in VW bits.
  assign o_r_out_c = VW'(o_qbit_c ? (w_shift - w_dvs) : w_shift);

endmodule

// File: rtl/shift_sub_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, DW steps per operation.
module shift_sub_divider
  import shift_div_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst,
  shift_sub_divider_if.slave bus
);

  localparam int unsigned CW = $clog2(DW + 1);

  state_t        r_state;
  state_t        w_next;

  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dvs;
  logic [VW-1:0] r_part;
  logic [DW-1:0] r_q;
  logic [CW-1:0] r_cnt;

  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_quotient;
  logic [VW-1:0] r_remainder;
  logic          r_dbz;

  logic [VW-1:0] w_r_out;
  logic          w_qbit;
  logic          w_last;
  logic          w_dvs_zero;

  shift_sub_step #(.VW(VW)) u_step (
    .i_r_in    (r_part),
    .i_bit     (r_dvd[DW-1]),
    .i_divisor (r_dvs),
    .o_r_out_c (w_r_out),
    .o_qbit_c  (w_qbit)
  );

  assign w_last     = (r_cnt == CW'(DW - 1));
  assign w_dvs_zero = (bus.divisor == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (bus.start) w_next = w_dvs_zero ? DONE : CALC;
      CALC: if (w_last)    w_next = DONE;
      DONE:                w_next = IDLE;
      default:             w_next = IDLE;
    endcase
  end

  // Datapath, step counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_part      <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_busy <= (w_next == CALC);
      r_done <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (bus.start && !w_dvs_zero) begin
            r_dvd  <= bus.dividend;
            r_dvs  <= bus.divisor;
            r_part <= '0;
            r_q    <= '0;
            r_cnt  <= '0;
          end else if (bus.start) begin
            r_quotient  <= DW'(DBZ_QUOTIENT);
            r_remainder <= '0;
            r_dbz       <= 1'b1;
          end
        end
        CALC: begin
          r_part <= w_r_out;
          r_dvd  <= {r_dvd[DW-2:0], 1'b0};
          r_q    <= {r_q[DW-2:0], w_qbit};
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            r_quotient  <= {r_q[DW-2:0], w_qbit};
            r_remainder <= w_r_out;
            r_dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed self-checking bench for shift_sub_divider at default widths.
module tb_shift_sub_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  shift_sub_divider_if #(.DW(8), .VW(4)) bus ();

  shift_sub_divider #(.DW(8), .VW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present operands for one cycle; returns at the first negedge after the start edge.
  task automatic issue(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    issue(8'd66, 4'd11);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL basic_latency got=%0d exp=9", lat); end
    checks++; if (bus.quotient !== 8'd6) begin errors++; $display("FAIL basic_q got=%0d exp=6", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL basic_r got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b exp=0", bus.div_by_zero); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_width got=%b exp=0", bus.done); end
    checks++; if (bus.quotient !== 8'd6) begin errors++; $display("FAIL basic_q_hold got=%0d exp=6", bus.quotient); end
  endtask

  task automatic test_vectors();
    logic [7:0] a_t [3] = '{8'd200, 8'd255, 8'd3};
    logic [3:0] b_t [3] = '{4'd7,   4'd1,   4'd11};
    logic [7:0] q_t [3] = '{8'd28,  8'd255, 8'd0};
    logic [3:0] r_t [3] = '{4'd4,   4'd0,   4'd3};
    int lat;
    for (int i = 0; i < 3; i++) begin
      issue(a_t[i], b_t[i]);
      wait_done(lat);
      checks++; if (lat != 9) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=9", i, lat); end
      checks++; if (bus.quotient !== q_t[i]) begin errors++; $display("FAIL vec%0d_q got=%0d exp=%0d", i, bus.quotient, q_t[i]); end
      checks++; if (bus.remainder !== r_t[i]) begin errors++; $display("FAIL vec%0d_r got=%0d exp=%0d", i, bus.remainder, r_t[i]); end
      checks++;
      if ((int'(bus.quotient) * int'(b_t[i]) + int'(bus.remainder) != int'(a_t[i])) || (bus.remainder >= b_t[i])) begin
        errors++; $display("FAIL vec%0d_invariant q=%0d r=%0d a=%0d b=%0d", i, bus.quotient, bus.remainder, a_t[i], b_t[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    issue(8'd33, 4'd0);
    wait_done(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++; if (bus.quotient !== 8'hFF) begin errors++; $display("FAIL dbz_q got=%h exp=ff", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL dbz_r got=%0d exp=0", bus.remainder); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b exp=1", bus.div_by_zero); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dbz_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL dbz_done_width got=%b exp=0", bus.done); end
    checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_hold got=%b exp=1", bus.div_by_zero); end
  endtask

  task automatic test_ignore_start();
    int lat;
    bit busy_ok;
    issue(8'd66, 4'd11);
    lat = 1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (lat == 3) begin
        bus.start = 1'b1; bus.dividend = 8'd99; bus.divisor = 4'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    checks++; if (!busy_ok) begin errors++; $display("FAIL ignore_busy got=dropped exp=held"); end
    checks++; if (lat != 9) begin errors++; $display("FAIL ignore_latency got=%0d exp=9", lat); end
    checks++; if (bus.quotient !== 8'd6) begin errors++; $display("FAIL ignore_q got=%0d exp=6", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL ignore_r got=%0d exp=0", bus.remainder); end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL ignore_idle got=busy%b/done%b exp=0/0", bus.busy, bus.done); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int pulses;
    issue(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL abort_q got=%0d exp=0", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL abort_r got=%0d exp=0", bus.remainder); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    issue(8'd33, 4'd3);
    wait_done(lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL abort_next_latency got=%0d exp=9", lat); end
    checks++; if (bus.quotient !== 8'd11) begin errors++; $display("FAIL abort_next_q got=%0d exp=11", bus.quotient); end
    checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL abort_next_r got=%0d exp=0", bus.remainder); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int lat2;
    int pulses;
    issue(8'd100, 4'd9);
    wait_done(lat);
    pulses = (bus.done === 1'b1) ? 1 : 0;
    checks++; if (bus.quotient !== 8'd11) begin errors++; $display("FAIL b2b_first_q got=%0d exp=11", bus.quotient); end
    checks++; if (bus.remainder !== 4'd1) begin errors++; $display("FAIL b2b_first_r got=%0d exp=1", bus.remainder); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_idle_done got=%b exp=0", bus.done); end
    bus.start = 1'b1; bus.dividend = 8'd250; bus.divisor = 4'd15;
    @(negedge clk);
    bus.start = 1'b0;
    lat2 = 1;
    while (bus.done !== 1'b1 && lat2 < 40) begin
      @(negedge clk);
      lat2++;
    end
    if (bus.done === 1'b1) pulses++;
    checks++; if (lat2 != 9) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=9", lat2); end
    checks++; if (bus.quotient !== 8'd16) begin errors++; $display("FAIL b2b_second_q got=%0d exp=16", bus.quotient); end
    checks++; if (bus.remainder !== 4'd10) begin errors++; $display("FAIL b2b_second_r got=%0d exp=10", bus.remainder); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    test_reset();
    test_basic();
    test_vectors();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
